// File: rtl/vga_pattern_ctrl.sv
// Frame-synchronous test-pattern selector: shadows one configuration request
// and applies it on the next frame_start so pattern switches never tear.
module vga_pattern_ctrl #(
    parameter int NUM_PATTERNS = 8,
    parameter int PAT_W        = 3,
    parameter int DWELL_W      = 8,
    parameter int FCNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_mode,
    input  logic [PAT_W-1:0]   cfg_pattern,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [PAT_W-1:0]   pat_sel,
    output logic               blank_force,
    output logic               pat_changed,
    output logic [1:0]         cur_mode,
    output logic [FCNT_W-1:0]  frame_cnt,
    output logic               dbg_state_o
);

    // Handshake: a request transfers in any cycle where cfg_valid && cfg_ready.
    // cfg_ready drops the cycle after a transfer and rises again the cycle after
    // the frame_start that applies the shadowed request.

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_PEND = 1'b1;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_AUTO  = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BLANK = 2'b11;

    localparam logic [PAT_W-1:0] PAT_MAX = PAT_W'(NUM_PATTERNS - 1);

    logic               state_q, state_d;
    logic               ready_q, ready_d;
    logic [1:0]         sh_mode_q, sh_mode_d;
    logic [PAT_W-1:0]   sh_pat_q, sh_pat_d;
    logic [DWELL_W-1:0] sh_dwell_q, sh_dwell_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               blank_q, blank_d;
    logic [1:0]         mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic               changed_q, changed_d;

    logic               xfer;
    logic               apply;
    logic [PAT_W-1:0]   pat_next;
    logic [PAT_W-1:0]   cap_pat;

    assign xfer     = cfg_valid && (state_q == ST_IDLE);
    assign apply    = frame_start && (state_q == ST_PEND);
    assign pat_next = (pat_q == PAT_MAX) ? '0 : pat_q + PAT_W'(1);
    assign cap_pat  = (int'(cfg_pattern) > NUM_PATTERNS - 1) ? PAT_MAX : cfg_pattern;

    always_comb begin
        state_d    = state_q;
        sh_mode_d  = sh_mode_q;
        sh_pat_d   = sh_pat_q;
        sh_dwell_d = sh_dwell_q;
        pat_d      = pat_q;
        blank_d    = blank_q;
        mode_d     = mode_q;
        dwell_d    = dwell_q;
        dcnt_d     = dcnt_q;
        fcnt_d     = frame_start ? fcnt_q + FCNT_W'(1) : fcnt_q;

        if (xfer) begin
            state_d    = ST_PEND;
            sh_mode_d  = cfg_mode;
            sh_pat_d   = cap_pat;
            sh_dwell_d = cfg_dwell;
        end

        // A pending application wins over the AUTO advance on the same frame.
        if (apply) begin
            state_d = ST_IDLE;
            case (sh_mode_q)
                MODE_BLANK: begin
                    blank_d = 1'b1;
                    mode_d  = MODE_BLANK;
                end
                MODE_HOLD: begin
                    pat_d   = sh_pat_q;
                    blank_d = 1'b0;
                    mode_d  = MODE_HOLD;
                end
                MODE_AUTO: begin
                    pat_d   = sh_pat_q;
                    blank_d = 1'b0;
                    mode_d  = MODE_AUTO;
                    dwell_d = sh_dwell_q;
                    dcnt_d  = '0;
                end
                default: begin
                    pat_d   = pat_next;
                    blank_d = 1'b0;
                    mode_d  = MODE_HOLD;
                end
            endcase
        end else if (frame_start && (mode_q == MODE_AUTO)) begin
            if (dcnt_q == dwell_q) begin
                pat_d  = pat_next;
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + DWELL_W'(1);
            end
        end

        ready_d   = (state_d == ST_IDLE);
        changed_d = (pat_d != pat_q) || (blank_d != blank_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            sh_mode_q  <= MODE_HOLD;
            sh_pat_q   <= '0;
            sh_dwell_q <= '0;
            pat_q      <= '0;
            blank_q    <= 1'b1;
            mode_q     <= MODE_BLANK;
            dwell_q    <= '0;
            dcnt_q     <= '0;
            fcnt_q     <= '0;
            changed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            sh_mode_q  <= sh_mode_d;
            sh_pat_q   <= sh_pat_d;
            sh_dwell_q <= sh_dwell_d;
            pat_q      <= pat_d;
            blank_q    <= blank_d;
            mode_q     <= mode_d;
            dwell_q    <= dwell_d;
            dcnt_q     <= dcnt_d;
            fcnt_q     <= fcnt_d;
            changed_q  <= changed_d;
        end
    end

    assign cfg_ready   = ready_q;
    assign pat_sel     = pat_q;
    assign blank_force = blank_q;
    assign pat_changed = changed_q;
    assign cur_mode    = mode_q;
    assign frame_cnt   = fcnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/vga_pattern_ctrl.md
# vga_pattern_ctrl

Frame-synchronous controller that selects which test pattern the VGA pixel datapath draws (colour bars, ramps, checkerboards, etc.). A single-entry valid/ready configuration port accepts a mode, a pattern index and a dwell count. The block shadows that request and applies it only on a frame boundary, so pattern switches never tear mid-frame. It sits between the configuration master and the pattern generators, and is driven by the timing generator's frame-start pulse.

## Interface
- NUM_PATTERNS, 8, number of selectable patterns; 2 ≤ NUM_PATTERNS ≤ 2^PAT_W
- PAT_W, 3, width of pattern index
- DWELL_W, 8, width of dwell (frames-per-pattern) field
- FCNT_W, 16, width of frame counter
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  single-cycle pulse from timing generator at start of vertical blank
- cfg_valid  in  1  configuration request valid
- cfg_ready  out  1  controller can accept a request
- cfg_mode  in  2  00 HOLD, 01 AUTO, 10 STEP, 11 BLANK
- cfg_pattern  in  PAT_W  pattern index (HOLD/AUTO start)
- cfg_dwell  in  DWELL_W  AUTO only: extra frames per pattern (0 = advance every frame)
- pat_sel  out  PAT_W  active pattern index to datapath mux
- blank_force  out  1  forces RGB to 0 when high
- pat_changed  out  1  one-cycle pulse when pat_sel or blank_force changes
- cur_mode  out  2  currently applied mode
- frame_cnt  out  FCNT_W  frame_start pulses since reset, wraps

## Operation
- Reset (async): pat_sel=0, blank_force=1, cur_mode=11 (BLANK), cfg_ready=1, pat_changed=0, frame_cnt=0, dwell_cnt=0, pending=0.
- States: IDLE (no pending request; cfg_ready=1) and PEND (request shadowed; cfg_ready=0).
- Handshake: a transfer occurs when cfg_valid && cfg_ready are both high. The block captures mode, pattern and dwell into shadow registers and moves to PEND. cfg_ready is 0 from the next cycle onward. cfg_valid held while cfg_ready=0 is not a transfer.
- PEND → IDLE on the next frame_start strictly after the transfer cycle. A frame_start in the same cycle as the transfer does not apply it. The request is applied on that frame_start, and cfg_ready returns to 1 the following cycle.
- Apply rules:
  - BLANK: blank_force=1, pat_sel unchanged.
  - HOLD: pat_sel=cfg_pattern, blank_force=0.
  - AUTO: pat_sel=cfg_pattern, blank_force=0, dwell_cnt=0.
  - STEP: pat_sel=pat_sel+1, wrapping NUM_PATTERNS-1→0; blank_force=0; cur_mode becomes HOLD. cfg_pattern is ignored.
- Out-of-range cfg_pattern (≥NUM_PATTERNS) is clamped to NUM_PATTERNS-1 at capture.
- AUTO running: on each frame_start with no request being applied:
  - if dwell_cnt==dwell, pat_sel advances with wrap and dwell_cnt=0;
  - otherwise dwell_cnt is incremented.
- Each pattern is therefore shown for dwell+1 frames.
- In HOLD and BLANK, frame_start has no effect on pat_sel or blank_force.
- An application on a frame_start takes priority over the AUTO advance in that same cycle.
- frame_cnt increments on every frame_start in all states, wrapping 2^FCNT_W-1→0.
- pat_changed pulses only when a registered value actually differs. Re-applying an identical HOLD gives no pulse.
- A reset in PEND discards the shadowed request.

## Timing
- All outputs are registered.
- frame_start at cycle N → pat_sel, blank_force, cur_mode, frame_cnt and pat_changed update at N+1. pat_changed is high for N+1 only.
- Transfer at cycle T → cfg_ready=0 from T+1 until the cycle after the applying frame_start.
- Minimum request-to-display latency is 1 frame_start. Maximum is one full frame plus 1 cycle.
- cfg_ready never toggles without a frame_start or a transfer.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then 3 frame_starts, no cfg → pat_sel=0, blank_force=1, frame_cnt=3, pat_changed never high.
- HOLD pattern 5, transferred mid-frame → cfg_ready=0 the next cycle. At the next frame_start+1: pat_sel=5, blank_force=0, pat_changed pulses once, cfg_ready=1 one cycle later.
- AUTO pattern 6 with dwell=1, then 6 frame_starts → pat_sel sequence 6,6,7,7,0,0 (wrap at NUM_PATTERNS=8).
- Transfer in the same cycle as frame_start → not applied at that frame_start; applied at the following one.
- STEP twice from pat_sel=7 (second request sent after cfg_ready returns) → pat_sel 0, then 1; cur_mode=HOLD.
- HOLD pattern 12 (PAT_W=4, NUM_PATTERNS=8) → pat_sel=7.
- Reset asserted while in PEND → outputs return to reset values; a subsequent frame_start applies nothing.
